mem_access_stage: RTL and testbench

Parametrised MEM pipeline stage for the MIPS core. It adds a multi-cycle data-memory access FSM with a stall output, byte/halfword/word loads and stores with sign/zero extension, and address range and alignment checking. It also resolves BEQ/BNE branch selection for the fetch stage. It sits between the EX/MEM and MEM/WB pipeline registers, and its stall output freezes the upstream stages.

---
 rtl/mem_stage_pkg.sv | 51 +++++
 rtl/data_memory_bank.sv | 24 ++
 rtl/mem_access_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane helpers for the MEM stage: access sizes, FSM states,
// byte-enable generation, store lane replication and load extension.
package mem_stage_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: byte_enables = 4'b0001 << lane;
      SIZE_HALF: byte_enables = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: byte_enables = 4'b1111;
      default:   byte_enables = 4'b0000;
    endcase
  endfunction

  // Narrow stores are replicated so whichever lane is enabled sees the right bits.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: store_lanes = {4{data[7:0]}};
      SIZE_HALF: store_lanes = {2{data[15:0]}};
      default:   store_lanes = data;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: extend_load = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SIZE_HALF: extend_load = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default:   extend_load = word;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_bank.sv
// Word-organised data RAM: synchronous byte-enabled write and synchronous read.
// Contents are never reset.
module data_memory_bank #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: multi-cycle data RAM access with stall, range/alignment checks,
// and BEQ/BNE next-PC selection. Build option MEM_ERR_STICKY_EN makes addr_error sticky.
//   state | meaning
//   IDLE  | ready; accepts a request or answers an erroneous one next cycle
//   BUSY  | access in flight, upstream stalled, cnt = BUSY cycles left (incl. this one)
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int          NBITS          = 32,
  parameter int          MEMORY_DEPTH   = 512,
  parameter logic [31:0] BASE_ADDR      = 32'h1001_0000,
  parameter int          ACCESS_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             mem_write,
  input  logic             mem_read,
  input  logic [1:0]       access_size,
  input  logic             load_unsigned,
  input  logic [NBITS-1:0] alu_result,
  input  logic [NBITS-1:0] write_data,
  input  logic             zero,
  input  logic             branch_eq,
  input  logic             branch_ne,
  input  logic [NBITS-1:0] pc_4,
  input  logic [NBITS-1:0] branch_address,
  output logic [NBITS-1:0] read_data,
  output logic [NBITS-1:0] data_address,
  output logic [NBITS-1:0] pc_or_branch,
  output logic             branch_taken,
  output logic             stall,
  output logic             resp_valid,
  output logic             addr_error
);

  localparam int               AW        = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [NBITS-1:0] MEM_BYTES = NBITS'(MEMORY_DEPTH * 4);
  localparam logic [3:0]       LAT_M1    = 4'(ACCESS_LATENCY - 1);

  mem_state_e       state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic [NBITS-1:0] offset;
  logic             req, err_check, err_flag, accept, err_req, done;
  logic             err_q;

  logic [AW-1:0]    cap_idx, op_idx;
  logic [1:0]       cap_lane, cap_size, op_lane, op_size;
  logic             cap_uns, cap_write, op_uns, op_write;
  logic [31:0]      cap_wdata, op_wdata;

  logic [3:0]       ram_we;
  logic             ram_re;
  logic [31:0]      ram_wdata, ram_rdata;

  logic             res_load, res_uns;
  logic [1:0]       res_size, res_lane;

  assign offset       = alu_result - BASE_ADDR;
  assign data_address = offset;
  assign branch_taken = (branch_eq & zero) | (branch_ne & ~zero);
  assign pc_or_branch = branch_taken ? branch_address : pc_4;
  assign req          = req_valid & (mem_read | mem_write);

  always_comb begin
    err_check = (access_size == SIZE_RSVD)
              | ((access_size == SIZE_HALF) && offset[0])
              | ((access_size == SIZE_WORD) && (offset[1:0] != 2'b00))
              | (offset >= MEM_BYTES);
  end

`ifdef MEM_ERR_STICKY_EN
  assign err_flag = err_check | err_q;
`else
  assign err_flag = err_check;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    err_req    = 1'b0;
    done       = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (req && !reset) begin
          if (err_flag) begin
            err_req = 1'b1;
          end else begin
            accept = 1'b1;
            stall  = 1'b1;
            // A single-cycle RAM completes on the accepting edge itself.
            if (ACCESS_LATENCY == 1) begin
              done = 1'b1;
            end else begin
              state_next = BUSY;
              cnt_next   = LAT_M1;
            end
          end
        end
      end
      BUSY: begin
        stall    = !reset;
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          done       = !reset;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_idx   <= offset[AW+1:2];
      cap_lane  <= offset[1:0];
      cap_size  <= access_size;
      cap_uns   <= load_unsigned;
      cap_wdata <= write_data;
      cap_write <= mem_write;
    end
  end

  assign op_idx   = (ACCESS_LATENCY == 1) ? offset[AW+1:2] : cap_idx;
  assign op_lane  = (ACCESS_LATENCY == 1) ? offset[1:0]    : cap_lane;
  assign op_size  = (ACCESS_LATENCY == 1) ? access_size    : cap_size;
  assign op_uns   = (ACCESS_LATENCY == 1) ? load_unsigned  : cap_uns;
  assign op_wdata = (ACCESS_LATENCY == 1) ? write_data     : cap_wdata;
  assign op_write = (ACCESS_LATENCY == 1) ? mem_write      : cap_write;

  assign ram_we    = (done && op_write) ? byte_enables(op_size, op_lane) : 4'b0000;
  assign ram_re    = done && !op_write;
  assign ram_wdata = store_lanes(op_size, op_wdata);

  data_memory_bank #(
    .DEPTH (MEMORY_DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (op_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      err_q      <= 1'b0;
      res_load   <= 1'b0;
      res_size   <= SIZE_WORD;
      res_lane   <= 2'b00;
      res_uns    <= 1'b0;
    end else begin
      resp_valid <= done | err_req;
`ifdef MEM_ERR_STICKY_EN
      err_q      <= err_q | err_req;
`else
      err_q      <= err_req;
`endif
      // Lane info is latched at completion so read_data holds across the next request.
      if (done) begin
        res_load <= !op_write;
        res_size <= op_size;
        res_lane <= op_lane;
        res_uns  <= op_uns;
      end else if (err_req) begin
        res_load <= 1'b0;
      end
    end
  end

  assign addr_error = err_q;
  assign read_data  = res_load ? extend_load(ram_rdata, res_size, res_lane, res_uns) : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: byte-array memory model with a
// per-cycle output compare, directed scenarios and randomized traffic.
module tb_mem_access_stage;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          LAT   = 2;
  localparam int          BYTES = 512 * 4;
`ifdef MEM_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, req_valid, mem_write, mem_read, load_unsigned, zero, branch_eq, branch_ne;
  logic [1:0]  access_size;
  logic [31:0] alu_result, write_data, pc_4, branch_address;
  logic [31:0] read_data, data_address, pc_or_branch;
  logic        branch_taken, stall, resp_valid, addr_error;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .mem_write(mem_write), .mem_read(mem_read),
    .access_size(access_size), .load_unsigned(load_unsigned), .alu_result(alu_result),
    .write_data(write_data), .zero(zero), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .pc_4(pc_4), .branch_address(branch_address), .read_data(read_data),
    .data_address(data_address), .pc_or_branch(pc_or_branch), .branch_taken(branch_taken),
    .stall(stall), .resp_valid(resp_valid), .addr_error(addr_error)
  );

  int checks = 0;
  int failures = 0;

  // model state
  logic [7:0]  mem_m [BYTES];
  int          cyc = 0;
  int          busy_end = 0;
  int          resp_cyc = -1;
  bit          pend_err, pend_write, pend_uns, sticky, prev_reset, chk_en;
  int          pend_off;
  logic [1:0]  pend_size;
  logic [31:0] pend_wd, m_rd;
  logic        exp_stall, exp_resp, exp_err, exp_bt;
  logic [31:0] exp_rd, exp_da, exp_pc;

  // inputs applied at the next do_cycle
  bit          rst_req, rand_br;
  logic        br_zero, br_eq, br_ne;
  logic [31:0] br_pc4, br_target;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input int o, input logic [1:0] sz, input bit uns);
    logic signed [31:0] s;
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = {24'd0, mem_m[o]};
        s = $signed(mem_m[o]);
      end
      2'd1: begin
        v = {16'd0, mem_m[o+1], mem_m[o]};
        s = $signed({mem_m[o+1], mem_m[o]});
      end
      default: begin
        v = {mem_m[o+3], mem_m[o+2], mem_m[o+1], mem_m[o]};
        s = $signed(v);
      end
    endcase
    return uns ? v : s;
  endfunction

  function automatic void model_eval();
    logic [31:0] off;
    bit err, err_pulse;
    if (prev_reset) begin
      busy_end = 0; resp_cyc = -1; sticky = 0; m_rd = '0;
    end
    exp_resp = 0; err_pulse = 0;
    if (cyc == resp_cyc) begin
      exp_resp = 1;
      if (pend_err) begin
        m_rd = '0; err_pulse = 1; sticky = 1;
      end else if (pend_write) begin
        m_rd = '0;
        for (int i = 0; i < (1 << pend_size); i++) mem_m[pend_off+i] = pend_wd[8*i +: 8];
      end else begin
        m_rd = model_load(pend_off, pend_size, pend_uns);
      end
    end
    exp_err = STICKY ? sticky : err_pulse;
    exp_stall = 0;
    off = alu_result - BASE;
    if (!reset) begin
      if (cyc < busy_end) exp_stall = 1;
      else if (req_valid && (mem_read || mem_write)) begin
        err = (access_size == 2'd3) || (access_size == 2'd1 && off % 2 != 0) ||
              (access_size == 2'd2 && off % 4 != 0) || (off >= BYTES) || (STICKY && sticky);
        if (err) begin
          resp_cyc = cyc + 1; pend_err = 1;
        end else begin
          exp_stall = 1; busy_end = cyc + LAT; resp_cyc = cyc + LAT; pend_err = 0;
          pend_write = mem_write; pend_off = int'(off); pend_size = access_size;
          pend_uns = load_unsigned; pend_wd = write_data;
        end
      end
    end
    exp_rd = m_rd;
    exp_da = off;
    exp_bt = zero ? branch_eq : branch_ne;
    exp_pc = exp_bt ? branch_address : pc_4;
    prev_reset = reset;
  endfunction

  task automatic do_cycle(input bit rv, input bit mw, input bit mr, input logic [1:0] sz,
                          input bit uns, input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset = rst_req; req_valid = rv; mem_write = mw; mem_read = mr;
    access_size = sz; load_unsigned = uns; alu_result = addr; write_data = wd;
    if (rand_br) begin
      zero = 1'($urandom); branch_eq = 1'($urandom); branch_ne = 1'($urandom);
      pc_4 = $urandom; branch_address = $urandom;
    end else begin
      zero = br_zero; branch_eq = br_eq; branch_ne = br_ne;
      pc_4 = br_pc4; branch_address = br_target;
    end
    cyc++;
    model_eval();
  endtask

  task automatic access(input bit mw, input bit mr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output int stalls, output logic [31:0] rd,
                        output logic err, output logic [31:0] da);
    bit done;
    do_cycle(1, mw, mr, sz, uns, addr, wd);
    #3;
    stalls = (stall === 1'b1) ? 1 : 0;
    da = data_address; lat = -1; rd = 'x; err = 'x; done = 0;
    for (int k = 1; k <= 20 && !done; k++) begin
      do_cycle(0, 0, 0, 2'd0, 0, addr, 32'd0);
      #3;
      if (resp_valid === 1'b1) begin
        lat = k; rd = read_data; err = addr_error; done = 1;
      end else if (stall === 1'b1) begin
        stalls++;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL resp_timeout cyc=%0d actual=no_resp required=resp_within_20", cyc);
    end
  endtask

  task automatic reset_pulse();
    rst_req = 1;
    do_cycle(0, 0, 0, 2'd0, 0, BASE, 32'd0);
    do_cycle(0, 0, 0, 2'd0, 0, BASE, 32'd0);
    rst_req = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'd0, stall}, {31'd0, exp_stall});
      check("resp_valid", {31'd0, resp_valid}, {31'd0, exp_resp});
      check("addr_error", {31'd0, addr_error}, {31'd0, exp_err});
      check("read_data", read_data, exp_rd);
      check("data_address", data_address, exp_da);
      check("branch_taken", {31'd0, branch_taken}, {31'd0, exp_bt});
      check("pc_or_branch", pc_or_branch, exp_pc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, st, r, o;
    logic [31:0] rd, da, addr;
    logic [1:0]  sz;
    logic        err;

    for (int i = 0; i < BYTES; i++) mem_m[i] = 8'h00;
    reset = 1; req_valid = 0; mem_write = 0; mem_read = 0; access_size = 0;
    load_unsigned = 0; alu_result = BASE; write_data = 0; zero = 0; branch_eq = 0;
    branch_ne = 0; pc_4 = 0; branch_address = 0;
    rand_br = 1; rst_req = 1; chk_en = 0; prev_reset = 0; sticky = 0; m_rd = 0;
    br_zero = 0; br_eq = 0; br_ne = 0; br_pc4 = 0; br_target = 0;
    do_cycle(0, 0, 0, 2'd0, 0, BASE, 32'd0);
    do_cycle(0, 0, 0, 2'd0, 0, BASE, 32'd0);
    chk_en = 1;
    rst_req = 0;
    #3;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_resp", {31'd0, resp_valid}, 32'd0);
    check("reset_rd", read_data, 32'd0);

    // preload the regions the random phase touches
    for (int a = 0; a < 64; a += 4) access(1, 0, 2'd2, 0, BASE + a, 32'd0, lat, st, rd, err, da);
    access(1, 0, 2'd2, 0, BASE + 2040, 32'd0, lat, st, rd, err, da);
    access(1, 0, 2'd2, 0, BASE + 2044, 32'd0, lat, st, rd, err, da);

    // 1: SW / LW round trip
    access(1, 0, 2'd2, 0, 32'h1001_0004, 32'hDEADBEEF, lat, st, rd, err, da);
    check("t1_sw_lat", 32'(lat), 32'd2);
    check("t1_sw_stalls", 32'(st), 32'd2);
    check("t1_sw_addr", da, 32'h4);
    access(0, 1, 2'd2, 0, 32'h1001_0004, 32'd0, lat, st, rd, err, da);
    check("t1_lw_data", rd, 32'hDEADBEEF);
    check("t1_lw_lat", 32'(lat), 32'd2);
    check("t1_lw_stalls", 32'(st), 32'd2);

    // 2: byte store, signed/unsigned byte loads
    access(1, 0, 2'd0, 0, 32'h1001_0005, 32'h0000_0080, lat, st, rd, err, da);
    check("t2_sb_rd_zero", rd, 32'd0);
    access(0, 1, 2'd0, 0, 32'h1001_0005, 32'd0, lat, st, rd, err, da);
    check("t2_lb", rd, 32'hFFFF_FF80);
    access(0, 1, 2'd0, 1, 32'h1001_0005, 32'd0, lat, st, rd, err, da);
    check("t2_lbu", rd, 32'h0000_0080);
    access(0, 1, 2'd2, 0, 32'h1001_0004, 32'd0, lat, st, rd, err, da);
    check("t2_lw", rd, 32'hDEAD_80EF);

    // 3: misaligned / out-of-range accesses
    access(0, 1, 2'd2, 0, 32'h1001_0004, 32'd0, lat, st, rd, err, da);
    check("t3_prior", rd, 32'hDEAD_80EF);
    access(0, 1, 2'd2, 0, 32'h1001_0002, 32'd0, lat, st, rd, err, da);
    check("t3_lw_mis_err", {31'd0, err}, 32'd1);
    check("t3_lw_mis_lat", 32'(lat), 32'd1);
    check("t3_lw_mis_stalls", 32'(st), 32'd0);
    check("t3_lw_mis_rd", rd, 32'd0);
    access(0, 1, 2'd1, 0, 32'h1001_0001, 32'd0, lat, st, rd, err, da);
    check("t3_lh_mis_err", {31'd0, err}, 32'd1);
    check("t3_lh_mis_lat", 32'(lat), 32'd1);
    access(1, 1, 2'd2, 0, 32'h1001_0800, 32'h5555_5555, lat, st, rd, err, da);
    check("t3_oor_err", {31'd0, err}, 32'd1);
    check("t3_oor_stalls", 32'(st), 32'd0);
    reset_pulse();
    access(0, 1, 2'd2, 0, 32'h1001_0004, 32'd0, lat, st, rd, err, da);
    check("t3_unchanged", rd, 32'hDEAD_80EF);
    access(0, 1, 2'd2, 0, 32'h1001_07FC, 32'd0, lat, st, rd, err, da);
    check("t3_last_word_err", {31'd0, err}, 32'd0);

    // 4: reset aborts an in-flight store
    do_cycle(1, 1, 0, 2'd2, 0, 32'h1001_0008, 32'h1234_5678);
    rst_req = 1;
    do_cycle(0, 0, 0, 2'd0, 0, 32'h1001_0008, 32'd0);
    do_cycle(0, 0, 0, 2'd0, 0, 32'h1001_0008, 32'd0);
    #3;
    check("t4_rst_stall", {31'd0, stall}, 32'd0);
    check("t4_rst_resp", {31'd0, resp_valid}, 32'd0);
    check("t4_rst_err", {31'd0, addr_error}, 32'd0);
    check("t4_rst_rd", read_data, 32'd0);
    rst_req = 0;
    access(0, 1, 2'd2, 0, 32'h1001_0008, 32'd0, lat, st, rd, err, da);
    check("t4_old_data", rd, 32'd0);

    // 5: branch selection
    rand_br = 0; br_pc4 = 32'h0040_0004; br_target = 32'h0040_0100;
    br_zero = 1; br_eq = 1; br_ne = 0;
    do_cycle(0, 0, 0, 2'd0, 0, BASE, 32'd0); #3;
    check("t5_beq_pc", pc_or_branch, 32'h0040_0100);
    check("t5_beq_taken", {31'd0, branch_taken}, 32'd1);
    br_zero = 0; br_eq = 0; br_ne = 1;
    do_cycle(0, 0, 0, 2'd0, 0, BASE, 32'd0); #3;
    check("t5_bne_pc", pc_or_branch, 32'h0040_0100);
    br_zero = 1; br_eq = 0; br_ne = 1;
    do_cycle(0, 0, 0, 2'd0, 0, BASE, 32'd0); #3;
    check("t5_bne_nt_pc", pc_or_branch, 32'h0040_0004);
    check("t5_bne_nt_taken", {31'd0, branch_taken}, 32'd0);
    rand_br = 1;

    // 6: error followed by a valid load
    access(0, 1, 2'd2, 0, 32'h1001_0006, 32'd0, lat, st, rd, err, da);
    check("t6_first_err", {31'd0, err}, 32'd1);
    access(0, 1, 2'd2, 0, 32'h1001_0004, 32'd0, lat, st, rd, err, da);
    if (STICKY) begin
      check("t6_sticky_err", {31'd0, err}, 32'd1);
      check("t6_sticky_lat", 32'(lat), 32'd1);
      check("t6_sticky_stalls", 32'(st), 32'd0);
      check("t6_sticky_rd", rd, 32'd0);
    end else begin
      check("t6_err_clear", {31'd0, err}, 32'd0);
      check("t6_lat", 32'(lat), 32'd2);
      check("t6_rd", rd, 32'hDEAD_80EF);
    end
    reset_pulse();

    // randomized traffic, including requests while busy and occasional resets
    for (int n = 0; n < 1500; n++) begin
      rst_req = ($urandom_range(0, 149) == 0);
      r = $urandom_range(0, 9);
      if (r < 8)       o = $urandom_range(0, 63);
      else if (r == 8) o = $urandom_range(2040, 2047);
      else             o = $urandom;
      addr = BASE + 32'(o);
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      do_cycle(1'($urandom), 1'($urandom), 1'($urandom), sz, 1'($urandom), addr, $urandom);
    end
    rst_req = 0;
    do_cycle(0, 0, 0, 2'd0, 0, BASE, 32'd0);
    do_cycle(0, 0, 0, 2'd0, 0, BASE, 32'd0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
